// File: rtl/l1_memory_arbiter_if.sv
// Bus bundle between the L1 caches, the arbiter and the memory port.
// The arbiter takes the master modport; caches and memory sit on the slave side.
interface l1_memory_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // I-cache side (read-only)
    logic                      IRequest;
    logic [ADDRESS_WIDTH-1:0]  IAddress;
    logic                      IDone;
    logic                      IError;
    logic [DATA_WIDTH-1:0]     IReadData;

    // D-cache side
    logic                      DRequest;
    logic                      DWrite;
    logic [DATA_WIDTH/8-1:0]   DStrobe;
    logic [ADDRESS_WIDTH-1:0]  DAddress;
    logic [DATA_WIDTH-1:0]     DWriteData;
    logic                      DDone;
    logic                      DError;
    logic [DATA_WIDTH-1:0]     DReadData;

    // Memory side
    logic                      MemRequest;
    logic                      MemWrite;
    logic [DATA_WIDTH/8-1:0]   MemStrobe;
    logic [ADDRESS_WIDTH-1:0]  MemAddress;
    logic [DATA_WIDTH-1:0]     MemWriteData;
    logic                      MemReady;
    logic [DATA_WIDTH-1:0]     MemReadData;

    modport master (
        input  IRequest, IAddress,
        output IDone, IError, IReadData,
        input  DRequest, DWrite, DStrobe, DAddress, DWriteData,
        output DDone, DError, DReadData,
        output MemRequest, MemWrite, MemStrobe, MemAddress, MemWriteData,
        input  MemReady, MemReadData
    );

    modport slave (
        output IRequest, IAddress,
        input  IDone, IError, IReadData,
        output DRequest, DWrite, DStrobe, DAddress, DWriteData,
        input  DDone, DError, DReadData,
        input  MemRequest, MemWrite, MemStrobe, MemAddress, MemWriteData,
        output MemReady, MemReadData
    );
endinterface

// File: rtl/l1_memory_arbiter.sv
// Merges L1 I-cache and D-cache miss/write traffic onto one memory port:
// one outstanding transaction, round-robin on ties, per-transaction timeout.
module l1_memory_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    l1_memory_arbiter_if.master bus
);
    localparam int SW    = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t                   state_q;
    owner_t                   owner_q;
    owner_t                   last_grant_q;
    logic [CNT_W-1:0]         count_q;
    logic                     mem_request_q;
    logic                     mem_write_q;
    logic [SW-1:0]            mem_strobe_q;
    logic [ADDRESS_WIDTH-1:0] mem_address_q;
    logic [DATA_WIDTH-1:0]    mem_write_data_q;
    logic [DATA_WIDTH-1:0]    read_data_q;
    logic                     error_q;
    logic                     i_done_q;
    logic                     d_done_q;

    // A lone requester wins outright; on a tie the one not granted last time wins.
    owner_t winner;
    always_comb begin
        winner = OWN_I;
        if (bus.IRequest && bus.DRequest) begin
            winner = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
        end else if (bus.DRequest) begin
            winner = OWN_D;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            owner_q          <= OWN_I;
            last_grant_q     <= OWN_D;
            count_q          <= '0;
            mem_request_q    <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_strobe_q     <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            read_data_q      <= '0;
            error_q          <= 1'b0;
            i_done_q         <= 1'b0;
            d_done_q         <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.IRequest || bus.DRequest) begin
                        owner_q       <= winner;
                        last_grant_q  <= winner;
                        count_q       <= '0;
                        mem_request_q <= 1'b1;
                        state_q       <= ST_WAIT;
                        if (winner == OWN_D) begin
                            mem_write_q      <= bus.DWrite;
                            mem_strobe_q     <= bus.DStrobe;
                            mem_address_q    <= bus.DAddress;
                            mem_write_data_q <= bus.DWriteData;
                        end else begin
                            mem_write_q      <= 1'b0;
                            mem_strobe_q     <= '1;
                            mem_address_q    <= bus.IAddress;
                            mem_write_data_q <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    // A MemReady on the final counted cycle still completes normally.
                    if (bus.MemReady) begin
                        read_data_q   <= bus.MemReadData;
                        error_q       <= 1'b0;
                        mem_request_q <= 1'b0;
                        i_done_q      <= (owner_q == OWN_I);
                        d_done_q      <= (owner_q == OWN_D);
                        state_q       <= ST_RESPOND;
                    end else if (TIMEOUT_EN && (count_q == CNT_LAST)) begin
                        read_data_q   <= '0;
                        error_q       <= 1'b1;
                        mem_request_q <= 1'b0;
                        i_done_q      <= (owner_q == OWN_I);
                        d_done_q      <= (owner_q == OWN_D);
                        state_q       <= ST_RESPOND;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                ST_RESPOND: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.IDone        = i_done_q;
    assign bus.IError       = error_q;
    assign bus.IReadData    = read_data_q;
    assign bus.DDone        = d_done_q;
    assign bus.DError       = error_q;
    assign bus.DReadData    = read_data_q;
    assign bus.MemRequest   = mem_request_q;
    assign bus.MemWrite     = mem_write_q;
    assign bus.MemStrobe    = mem_strobe_q;
    assign bus.MemAddress   = mem_address_q;
    assign bus.MemWriteData = mem_write_data_q;
endmodule

// File: tb/tb_l1_memory_arbiter.sv
// Bench for l1_memory_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model of grant order, memory fields, latency and responses.
module tb_l1_memory_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_memory_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    l1_memory_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_txn  = 0;
    bit last_d = 1'b1;   // model's record of the previous grant (1 = D-cache)

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.IRequest    = 1'b0;
        bus.IAddress    = '0;
        bus.DRequest    = 1'b0;
        bus.DWrite      = 1'b0;
        bus.DStrobe     = '0;
        bus.DAddress    = '0;
        bus.DWriteData  = '0;
        bus.MemReady    = 1'b0;
        bus.MemReadData = '0;
    endtask

    task automatic set_i(input logic [AW-1:0] addr);
        bus.IRequest = 1'b1;
        bus.IAddress = addr;
    endtask

    task automatic set_d(input logic wr, input logic [SW-1:0] strb,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.DRequest   = 1'b1;
        bus.DWrite     = wr;
        bus.DStrobe    = strb;
        bus.DAddress   = addr;
        bus.DWriteData = data;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cache_outs"},
              {bus.IDone, bus.IError, bus.IReadData, bus.DDone, bus.DError, bus.DReadData},
              '0);
        check({tag, "_mem_outs"},
              {bus.MemRequest, bus.MemWrite, bus.MemStrobe, bus.MemAddress, bus.MemWriteData},
              '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        last_d = 1'b1;
    endtask

    // One transaction: find MemRequest, predict the grant, answer after `lat` WAIT cycles
    // (lat >= T means memory is silent and answers late, in the response cycle).
    task automatic serve(input int lat, input logic [DW-1:0] rdata, input int exp_wait,
                         input bit drop, output bit win_d);
        int             wc;
        int             dcyc;
        int             rpos;
        logic           exp_write;
        logic [SW-1:0]  exp_strb;
        logic [AW-1:0]  exp_addr;
        logic [DW-1:0]  exp_wdata;
        logic [DW-1:0]  exp_data;
        logic           exp_err;

        wc = 0;
        do begin
            @(negedge clk);
            bus.MemReady = 1'b0;
            wc++;
        end while (!bus.MemRequest && wc < 10);
        if (exp_wait > 0) check("req_to_memreq_cycles", wc, exp_wait);

        win_d     = (bus.IRequest && bus.DRequest) ? !last_d : bus.DRequest;
        last_d    = win_d;
        exp_write = win_d ? bus.DWrite : 1'b0;
        exp_strb  = win_d ? bus.DStrobe : '1;
        exp_addr  = win_d ? bus.DAddress : bus.IAddress;
        exp_wdata = bus.DWriteData;
        exp_err   = (lat >= T);
        exp_data  = exp_err ? '0 : rdata;
        dcyc      = exp_err ? T : lat + 1;
        rpos      = exp_err ? T : lat;

        check("mem_fields", {bus.MemRequest, bus.MemWrite, bus.MemStrobe, bus.MemAddress},
              {1'b1, exp_write, exp_strb, exp_addr});
        if (win_d) check("mem_wdata", bus.MemWriteData, exp_wdata);

        bus.MemReadData = rdata;
        bus.MemReady    = (rpos == 0);
        for (int i = 1; i <= dcyc; i++) begin
            @(negedge clk);
            bus.MemReady = (i == rpos);
            if (i < dcyc) begin
                check("wait_hold",
                      {bus.MemRequest, bus.IDone, bus.DDone, bus.MemWrite, bus.MemStrobe, bus.MemAddress},
                      {1'b1, 1'b0, 1'b0, exp_write, exp_strb, exp_addr});
            end else begin
                check("done_pair", {bus.MemRequest, bus.IDone, bus.DDone}, {1'b0, !win_d, win_d});
                if (win_d) begin
                    check("d_error", bus.DError, exp_err);
                    if (!exp_write || exp_err) check("d_rdata", bus.DReadData, exp_data);
                end else begin
                    check("i_error", bus.IError, exp_err);
                    check("i_rdata", bus.IReadData, exp_data);
                end
                if (drop) begin
                    if (win_d) bus.DRequest = 1'b0;
                    else       bus.IRequest = 1'b0;
                end
            end
        end
        n_txn++;
        $display("txn %0d: %s addr=%h wr=%0d strb=%h lat=%0d err=%0d data=%h",
                 n_txn, win_d ? "D" : "I", exp_addr, exp_write, exp_strb, lat, exp_err, exp_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit w;
        int ew;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // I-cache only, memory answers 3 cycles after MemRequest
        @(negedge clk);
        set_i(32'h0000_0100);
        serve(3, 32'hDEAD_BEEF, 1, 1'b1, w);
        check("i_only_grant", w, 1'b0);

        // Tie after reset: I first, then the held D write
        do_reset();
        set_i(32'h0000_0104);
        set_d(1'b1, 4'h3, 32'h0000_0200, 32'h1234_5678);
        serve(1, 32'h1111_1111, 1, 1'b1, w);
        check("tie_first_is_i", w, 1'b0);
        serve(2, 32'h2222_2222, 2, 1'b1, w);
        check("tie_second_is_d", w, 1'b1);

        // Fairness: both held for six transactions
        @(negedge clk);
        set_i(32'h0000_1000);
        set_d(1'b0, 4'hF, 32'h0000_2000, 32'h0);
        for (int k = 0; k < 6; k++) begin
            serve(1, $urandom, (k == 0) ? 1 : 2, 1'b0, w);
            check("fair_alternate", w, k[0]);
        end
        clear_inputs();

        // Zero-wait memory: Done two cycles after request, MemRequest every three cycles
        @(negedge clk);
        set_i(32'h0000_0400);
        for (int k = 0; k < 3; k++) serve(0, $urandom, (k == 0) ? 1 : 2, (k == 2), w);

        // Timeout: silent memory, then a late MemReady in the response cycle
        @(negedge clk);
        set_d(1'b0, 4'hF, 32'h0000_0500, 32'h0);
        serve(1000, 32'hBAD0_BAD0, 1, 1'b1, w);
        @(negedge clk);
        bus.MemReady = 1'b0;
        check("late_ready_ignored", {bus.MemRequest, bus.IDone, bus.DDone}, 3'b000);

        // Reset two cycles into a D transaction
        @(negedge clk);
        set_d(1'b1, 4'hC, 32'h0000_0300, 32'hCAFE_F00D);
        @(negedge clk);
        check("rw_memreq_up", bus.MemRequest, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rw_after_reset");
        rst = 1'b0;
        clear_inputs();
        last_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rw_no_ddone", {bus.MemRequest, bus.DDone}, 2'b00);
        end
        set_i(32'h0000_0600);
        serve(1, 32'h600D_600D, 1, 1'b1, w);
        check("rw_i_after_reset", w, 1'b0);

        // Random traffic
        @(negedge clk);
        if ($urandom_range(0, 1) != 0) set_i($urandom);
        if ($urandom_range(0, 1) != 0) set_d($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom);
        if (!bus.IRequest && !bus.DRequest) set_i($urandom);
        ew = 1;
        for (int k = 0; k < 40; k++) begin
            serve($urandom_range(0, 5), $urandom, ew, 1'b1, w);
            if ($urandom_range(0, 1) != 0) begin
                if (w) set_d($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom);
                else   set_i($urandom);
            end
            if (!bus.IRequest && !bus.DRequest) begin
                if ($urandom_range(0, 1) != 0) set_i($urandom);
                else set_d($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom);
            end
            ew = 2;
        end
        clear_inputs();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
